// File: rtl/ctrl_pkg.sv
// Shared control encodings: op1 classes, FSM state codes, pc/wb selects, illegal-op2 mask.
// Reused by the decoder and the multicycle sequencer.
package ctrl_pkg;

    localparam logic [3:0] OP1_ALU_R  = 4'b0000;
    localparam logic [3:0] OP1_ALU_I  = 4'b1000;
    localparam logic [3:0] OP1_CMP_R  = 4'b0010;
    localparam logic [3:0] OP1_CMP_I  = 4'b1010;
    localparam logic [3:0] OP1_LOAD   = 4'b1001;
    localparam logic [3:0] OP1_STORE  = 4'b0101;
    localparam logic [3:0] OP1_BRANCH = 4'b0110;
    localparam logic [3:0] OP1_JAL    = 4'b1011;

    typedef enum logic [2:0] {
        CLS_ALU_R  = 3'd0,
        CLS_ALU_I  = 3'd1,
        CLS_CMP_R  = 3'd2,
        CLS_CMP_I  = 3'd3,
        CLS_LOAD   = 3'd4,
        CLS_STORE  = 3'd5,
        CLS_BRANCH = 3'd6,
        CLS_JAL    = 3'd7
    } cls_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_e;

    localparam logic [1:0] PC_SEL_SEQ = 2'd0;
    localparam logic [1:0] PC_SEL_BR  = 2'd1;
    localparam logic [1:0] PC_SEL_JAL = 2'd2;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    // Bit n set => op2 == n is not a defined ALU function (2,3,7,8,9,A,B,F).
    localparam logic [15:0] ILLEGAL_OP2_MASK = 16'h8F8C;

    function automatic logic cls_uses_imm(input cls_e c);
        return (c == CLS_ALU_I) || (c == CLS_CMP_I) || (c == CLS_LOAD) ||
               (c == CLS_STORE) || (c == CLS_JAL);
    endfunction

endpackage

// File: rtl/op_classify.sv
// Combinational opcode classifier: op1/op2 -> instruction class and legality flag.
module op_classify
    import ctrl_pkg::*;
(
    input  logic [3:0] op1_i,
    input  logic [3:0] op2_i,
    output cls_e       cls_o,
    output logic       legal_o
);

    always_comb begin
        cls_o   = CLS_ALU_R;
        legal_o = 1'b1;
        case (op1_i)
            OP1_ALU_R:  cls_o = CLS_ALU_R;
            OP1_ALU_I:  cls_o = CLS_ALU_I;
            OP1_CMP_R:  cls_o = CLS_CMP_R;
            OP1_CMP_I:  cls_o = CLS_CMP_I;
            OP1_LOAD:   cls_o = CLS_LOAD;
            OP1_STORE:  cls_o = CLS_STORE;
            OP1_BRANCH: cls_o = CLS_BRANCH;
            OP1_JAL:    cls_o = CLS_JAL;
            default:    legal_o = 1'b0;
        endcase
        // The function field only carries meaning for the ALU classes.
        if ((cls_o == CLS_ALU_R || cls_o == CLS_ALU_I) && ILLEGAL_OP2_MASK[op2_i])
            legal_o = 1'b0;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with an absorbing TRAP state.
// Strobes decode from state and latched class; retired counter and sticky illegal flag are registered.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op1,
    input  logic [3:0]       op2,
    input  logic             cond_true,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             alu_src_imm,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             illegal,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    cls_e             cls_q, cls_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    cls_e dec_cls;
    logic dec_legal;

    op_classify u_classify (
        .op1_i   (op1),
        .op2_i   (op2),
        .cls_o   (dec_cls),
        .legal_o (dec_legal)
    );

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                cls_d = dec_cls;
                if (!dec_legal) begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cls_q == CLS_BRANCH) begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else if (cls_q == CLS_LOAD || cls_q == CLS_STORE) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    if (cls_q == CLS_STORE) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
        retired_d = retired_q + CNT_W'(retire);
    end

    // Strobes are held low while reset is asserted so a pending request drops immediately.
    always_comb begin
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = PC_SEL_SEQ;
        alu_src_imm = 1'b0;
        rf_we       = 1'b0;
        wb_sel      = WB_SEL_ALU;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                end
                ST_EXEC: begin
                    alu_src_imm = cls_uses_imm(cls_q);
                    if (cls_q == CLS_BRANCH) begin
                        pc_we  = 1'b1;
                        pc_sel = cond_true ? PC_SEL_BR : PC_SEL_SEQ;
                    end
                end
                ST_MEM: begin
                    dmem_req    = 1'b1;
                    dmem_we     = (cls_q == CLS_STORE);
                    alu_src_imm = 1'b1;
                    pc_we       = dmem_ack && (cls_q == CLS_STORE);
                end
                ST_WB: begin
                    rf_we  = 1'b1;
                    pc_we  = 1'b1;
                    pc_sel = (cls_q == CLS_JAL) ? PC_SEL_JAL : PC_SEL_SEQ;
                    if (cls_q == CLS_LOAD)     wb_sel = WB_SEL_MEM;
                    else if (cls_q == CLS_JAL) wb_sel = WB_SEL_PC4;
                    else                       wb_sel = WB_SEL_ALU;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            cls_q     <= CLS_ALU_R;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    assign state_o = state_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state/strobe vectors with hand-computed values.
// A second instance with a 2-bit counter shares the stimulus to exercise counter wrap.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] op1, op2;
    logic       cond_true, imem_ack, dmem_ack;

    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_src_imm, rf_we, illegal;
    logic [1:0]  pc_sel, wb_sel;
    logic [2:0]  state_o;
    logic [31:0] retired;

    logic        imem_req_w, dmem_req_w, dmem_we_w, ir_we_w, pc_we_w, alu_src_imm_w, rf_we_w, illegal_w;
    logic [1:0]  pc_sel_w, wb_sel_w;
    logic [2:0]  state_o_w;
    logic [1:0]  retired_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op1(op1), .op2(op2), .cond_true(cond_true),
        .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ack(dmem_ack), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .alu_src_imm(alu_src_imm), .rf_we(rf_we), .wb_sel(wb_sel), .illegal(illegal),
        .state_o(state_o), .retired(retired)
    );

    multicycle_ctrl #(.CNT_W(2)) dut_w (
        .clk(clk), .reset(reset), .op1(op1), .op2(op2), .cond_true(cond_true),
        .imem_req(imem_req_w), .imem_ack(imem_ack), .dmem_req(dmem_req_w), .dmem_we(dmem_we_w),
        .dmem_ack(dmem_ack), .ir_we(ir_we_w), .pc_we(pc_we_w), .pc_sel(pc_sel_w),
        .alu_src_imm(alu_src_imm_w), .rf_we(rf_we_w), .wb_sel(wb_sel_w), .illegal(illegal_w),
        .state_o(state_o_w), .retired(retired_w)
    );

    // {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel[1:0], alu_src_imm, rf_we, wb_sel[1:0]}
    logic [10:0] strobes;
    assign strobes = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_src_imm, rf_we, wb_sel};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply acks/cond for one cycle, check state and strobes, then advance past the edge.
    task automatic cyc(input string tag, input logic ia, input logic da, input logic cd,
                       input logic [2:0] es, input logic [10:0] ex);
        imem_ack  = ia;
        dmem_ack  = da;
        cond_true = cd;
        #1;
        check_val({tag, "_state"}, {29'd0, state_o}, {29'd0, es});
        check_val({tag, "_strobes"}, {21'd0, strobes}, {21'd0, ex});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        check_val("rst_state", {29'd0, state_o}, 32'd0);
        check_val("rst_strobes", {21'd0, strobes}, 32'd0);
        check_val("rst_illegal", {31'd0, illegal}, 32'd0);
        check_val("rst_retired", retired, 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; op1 = 4'h0; op2 = 4'h0; cond_true = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // ALU-R add; simultaneous dmem_ack must be ignored outside MEM
        op1 = 4'b0000; op2 = 4'b0000;
        cyc("alur_f", 1, 1, 0, 3'd0, 11'h480);
        cyc("alur_d", 0, 1, 0, 3'd1, 11'h000);
        cyc("alur_e", 0, 1, 0, 3'd2, 11'h000);
        cyc("alur_w", 0, 1, 0, 3'd4, 11'h044);
        check_val("alur_ret", retired, 32'd1);

        // LOAD with dmem_ack after three wait cycles
        op1 = 4'b1001;
        cyc("ld_f", 1, 0, 0, 3'd0, 11'h480);
        cyc("ld_d", 0, 0, 0, 3'd1, 11'h000);
        cyc("ld_e", 0, 0, 0, 3'd2, 11'h008);
        cyc("ld_m0", 0, 0, 0, 3'd3, 11'h208);
        cyc("ld_m1", 1, 0, 0, 3'd3, 11'h208);
        cyc("ld_m2", 0, 0, 0, 3'd3, 11'h208);
        cyc("ld_m3", 0, 1, 0, 3'd3, 11'h208);
        check_val("ld_ret_mid", retired, 32'd1);
        cyc("ld_w", 0, 0, 0, 3'd4, 11'h045);
        check_val("ld_ret", retired, 32'd2);

        // BRANCH taken, with one fetch stall
        op1 = 4'b0110;
        cyc("bt_f0", 0, 0, 1, 3'd0, 11'h400);
        cyc("bt_f1", 1, 0, 1, 3'd0, 11'h480);
        cyc("bt_d", 0, 0, 1, 3'd1, 11'h000);
        cyc("bt_e", 0, 0, 1, 3'd2, 11'h050);
        check_val("bt_ret", retired, 32'd3);

        // BRANCH not taken; fourth retirement wraps the 2-bit counter
        cyc("bn_f", 1, 0, 0, 3'd0, 11'h480);
        cyc("bn_d", 0, 0, 0, 3'd1, 11'h000);
        cyc("bn_e", 0, 0, 0, 3'd2, 11'h040);
        check_val("bn_ret", retired, 32'd4);
        check_val("wrap_ret", {30'd0, retired_w}, 32'd0);

        // JAL
        op1 = 4'b1011;
        cyc("jal_f", 1, 0, 0, 3'd0, 11'h480);
        cyc("jal_d", 0, 0, 0, 3'd1, 11'h000);
        cyc("jal_e", 0, 0, 0, 3'd2, 11'h008);
        cyc("jal_w", 0, 0, 0, 3'd4, 11'h066);
        check_val("jal_ret", retired, 32'd5);
        check_val("wrap_ret1", {30'd0, retired_w}, 32'd1);

        // STORE with immediate ack
        op1 = 4'b0101;
        cyc("st_f", 1, 0, 0, 3'd0, 11'h480);
        cyc("st_d", 0, 0, 0, 3'd1, 11'h000);
        cyc("st_e", 0, 0, 0, 3'd2, 11'h008);
        cyc("st_m", 0, 1, 0, 3'd3, 11'h348);
        check_val("st_next", {29'd0, state_o}, 32'd0);
        check_val("st_ret", retired, 32'd6);

        // ALU-I with a legal function
        op1 = 4'b1000; op2 = 4'h4;
        cyc("alui_f", 1, 0, 0, 3'd0, 11'h480);
        cyc("alui_d", 0, 0, 0, 3'd1, 11'h000);
        cyc("alui_e", 0, 0, 0, 3'd2, 11'h008);
        cyc("alui_w", 0, 0, 0, 3'd4, 11'h044);
        check_val("alui_ret", retired, 32'd7);

        // Illegal op1: trap is absorbing, no fetch even with imem_ack
        op1 = 4'b1111; op2 = 4'h0;
        cyc("ill1_f", 1, 0, 0, 3'd0, 11'h480);
        cyc("ill1_d", 0, 0, 0, 3'd1, 11'h000);
        cyc("ill1_t0", 1, 1, 0, 3'd7, 11'h000);
        cyc("ill1_t1", 1, 1, 0, 3'd7, 11'h000);
        check_val("ill1_flag", {31'd0, illegal}, 32'd1);
        check_val("ill1_ret", retired, 32'd7);
        do_reset();

        // ALU-R with illegal function 7
        op1 = 4'b0000; op2 = 4'b0111;
        cyc("ill2_f", 1, 0, 0, 3'd0, 11'h480);
        cyc("ill2_d", 0, 0, 0, 3'd1, 11'h000);
        cyc("ill2_t", 1, 0, 0, 3'd7, 11'h000);
        check_val("ill2_flag", {31'd0, illegal}, 32'd1);
        do_reset();

        // Retire one, then reset during a STORE wait in MEM
        op1 = 4'b0110; op2 = 4'h0;
        cyc("pre_f", 1, 0, 0, 3'd0, 11'h480);
        cyc("pre_d", 0, 0, 0, 3'd1, 11'h000);
        cyc("pre_e", 0, 0, 0, 3'd2, 11'h040);
        check_val("pre_ret", retired, 32'd1);
        op1 = 4'b0101;
        cyc("sr_f", 1, 0, 0, 3'd0, 11'h480);
        cyc("sr_d", 0, 0, 0, 3'd1, 11'h000);
        cyc("sr_e", 0, 0, 0, 3'd2, 11'h008);
        imem_ack = 1'b0; dmem_ack = 1'b0;
        #1;
        check_val("sr_m_strobes", {21'd0, strobes}, 32'h308);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("sr_rst_dmem", {31'd0, dmem_req}, 32'd0);
        check_val("sr_rst_state", {29'd0, state_o}, 32'd0);
        check_val("sr_rst_ret", retired, 32'd0);
        reset = 1'b0;
        cyc("sr_after", 0, 0, 0, 3'd0, 11'h400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
